// File: rtl/output_controller_pkg.sv
// Shared router definitions: packet layout, phase encoding and VC buffer states.
package output_controller_pkg;

  localparam int PKT_W   = 64;
  localparam int HOP_MSB = 55;
  localparam int HOP_LSB = 48;

  typedef enum logic {
    POL_EVEN = 1'b0,
    POL_ODD  = 1'b1
  } polarity_e;

  typedef enum logic [1:0] {
    VC_EMPTY   = 2'd0,
    VC_FULL    = 2'd1,
    VC_BLOCKED = 2'd2
  } vc_state_e;

endpackage

// File: rtl/output_controller_if.sv
// Write handshake from the output arbiter and the outbound si/ri/di link.
interface output_controller_if;
  import output_controller_pkg::*;

  logic             wr_valid;
  logic [PKT_W-1:0] wr_data;
  logic             wr_ready;
  logic             ro;
  logic             so;
  logic [PKT_W-1:0] dout;

  modport master (
    output wr_valid, wr_data, ro,
    input  wr_ready, so, dout
  );

  modport slave (
    input  wr_valid, wr_data, ro,
    output wr_ready, so, dout
  );

endinterface

// File: rtl/oc_vc_buffer.sv
// One virtual-channel buffer: packet register, EMPTY/FULL/BLOCKED FSM and
// saturating stall counter. Writes and link opportunities never coincide.
module oc_vc_buffer
  import output_controller_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [PKT_W-1:0] wr_data_i,
  input  logic             opp_i,
  input  logic             ro_i,
  output logic             full_o,
  output logic             send_o,
  output logic [PKT_W-1:0] data_o,
  output logic             over_limit_o
);

  localparam logic [7:0] LIMIT_C = 8'(STALL_LIMIT);

  vc_state_e        state_q, state_d;
  logic [PKT_W-1:0] data_q, data_d;
  logic [7:0]       cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= VC_EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    send_o  = 1'b0;
    case (state_q)
      VC_EMPTY: begin
        if (wr_en_i) begin
          state_d = VC_FULL;
          data_d  = wr_data_i;
        end
      end
      VC_FULL, VC_BLOCKED: begin
        if (opp_i) begin
          if (ro_i) begin
            send_o  = 1'b1;
            state_d = VC_EMPTY;
            data_d  = '0;
            cnt_d   = '0;
          end else begin
            state_d = VC_BLOCKED;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = VC_EMPTY;
    endcase
  end

  // Compared against the next count so the top-level stall flop tracks this edge.
  assign over_limit_o = (cnt_d >= LIMIT_C);
  assign full_o       = (state_q != VC_EMPTY);
  assign data_o       = data_q;

endmodule

// File: rtl/output_controller.sv
// Transmit-side link controller: two phase-interleaved VC buffers feeding one link.
// Optional packet counter enabled by OUTPUT_CONTROLLER_PKT_COUNT_EN.
module output_controller
  import output_controller_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                polarity,
  output_controller_if.slave  link,
  output logic                full_even,
  output logic                full_odd,
  output logic                err_overflow,
  output logic                stall
`ifdef OUTPUT_CONTROLLER_PKT_COUNT_EN
  , output logic [15:0]       pkt_count
`endif
);

  logic             wr_accept;
  logic             send_even, send_odd;
  logic             over_even, over_odd;
  logic [PKT_W-1:0] data_even, data_odd;
  logic             so_q, so_d;
  logic [PKT_W-1:0] dout_q, dout_d;
  logic             err_q, err_d;
  logic             stall_q, stall_d;

  assign link.wr_ready = (polarity == POL_ODD) ? !full_odd : !full_even;
  assign wr_accept     = link.wr_valid && link.wr_ready;

  // Even buffer is written in the even phase and drained in the odd phase.
  oc_vc_buffer #(.STALL_LIMIT(STALL_LIMIT)) u_vc_even (
    .clk          (clk),
    .reset        (reset),
    .wr_en_i      (wr_accept && (polarity == POL_EVEN)),
    .wr_data_i    (link.wr_data),
    .opp_i        (polarity == POL_ODD),
    .ro_i         (link.ro),
    .full_o       (full_even),
    .send_o       (send_even),
    .data_o       (data_even),
    .over_limit_o (over_even)
  );

  oc_vc_buffer #(.STALL_LIMIT(STALL_LIMIT)) u_vc_odd (
    .clk          (clk),
    .reset        (reset),
    .wr_en_i      (wr_accept && (polarity == POL_ODD)),
    .wr_data_i    (link.wr_data),
    .opp_i        (polarity == POL_EVEN),
    .ro_i         (link.ro),
    .full_o       (full_odd),
    .send_o       (send_odd),
    .data_o       (data_odd),
    .over_limit_o (over_odd)
  );

  always_comb begin
    so_d    = send_even || send_odd;
    dout_d  = '0;
    if (send_even)     dout_d = data_even;
    else if (send_odd) dout_d = data_odd;
    err_d   = err_q || (link.wr_valid && !link.wr_ready);
    stall_d = over_even || over_odd;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      so_q    <= 1'b0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      so_q    <= so_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign link.so      = so_q;
  assign link.dout    = dout_q;
  assign err_overflow = err_q;
  assign stall        = stall_q;

`ifdef OUTPUT_CONTROLLER_PKT_COUNT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  assign pkt_cnt_d = so_d ? pkt_cnt_q + 16'd1 : pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) pkt_cnt_q <= '0;
    else        pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_count = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_output_controller.sv
// Bench for output_controller: constant vector table, directed sequences and
// randomized traffic against a packet-level reference model.
module tb_output_controller;

  localparam int unsigned LIMIT = 3;

  logic clk = 1'b0;
  logic reset;
  logic polarity;
  logic full_even, full_odd, err_overflow, stall;
`ifdef OUTPUT_CONTROLLER_PKT_COUNT_EN
  logic [15:0] pkt_count;
`endif

  output_controller_if bus ();

  output_controller #(.STALL_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .polarity     (polarity),
    .link         (bus),
    .full_even    (full_even),
    .full_odd     (full_odd),
    .err_overflow (err_overflow),
    .stall        (stall)
`ifdef OUTPUT_CONTROLLER_PKT_COUNT_EN
    , .pkt_count  (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = even VC, 1 = odd VC.
  bit          occ[2];
  logic [63:0] mdata[2];
  int          mcnt[2];
  bit          m_so, m_err, m_stall;
  logic [63:0] m_dout;
  int unsigned m_pkts;

  task automatic model_edge(input bit rst, input bit pol, input bit wv,
                            input logic [63:0] wd, input bit ro);
    int src;
    if (!rst) begin
      occ = '{0, 0}; mdata = '{64'd0, 64'd0}; mcnt = '{0, 0};
      m_so = 0; m_dout = '0; m_err = 0; m_stall = 0; m_pkts = 0;
      return;
    end
    src    = pol ? 0 : 1;
    m_so   = occ[src] && ro;
    m_dout = m_so ? mdata[src] : 64'd0;
    if (m_so) begin
      occ[src] = 0; mdata[src] = '0; mcnt[src] = 0;
      m_pkts = (m_pkts + 1) % 65536;
    end else if (occ[src] && mcnt[src] < 255) begin
      mcnt[src]++;
    end
    if (wv && !occ[pol]) begin
      occ[pol] = 1; mdata[pol] = wd;
    end else if (wv) begin
      m_err = 1;
    end
    m_stall = (mcnt[0] >= int'(LIMIT)) || (mcnt[1] >= int'(LIMIT));
  endtask

  task automatic step(input bit rst, input bit pol, input bit wv,
                      input logic [63:0] wd, input bit ro);
    reset = rst; polarity = pol; bus.wr_valid = wv; bus.wr_data = wd; bus.ro = ro;
    #1;
    chk("wr_ready", {63'd0, bus.wr_ready}, {63'd0, !occ[pol]});
    @(posedge clk);
    model_edge(rst, pol, wv, wd, ro);
    #1;
    chk("so", {63'd0, bus.so}, {63'd0, m_so});
    chk("dout", bus.dout, m_dout);
    chk("full_even", {63'd0, full_even}, {63'd0, occ[0]});
    chk("full_odd", {63'd0, full_odd}, {63'd0, occ[1]});
    chk("err_overflow", {63'd0, err_overflow}, {63'd0, m_err});
    chk("stall", {63'd0, stall}, {63'd0, m_stall});
`ifdef OUTPUT_CONTROLLER_PKT_COUNT_EN
    chk("pkt_count", {48'd0, pkt_count}, {32'd0, m_pkts});
`endif
  endtask

  typedef struct {
    bit          pol, wv, ro;
    logic [63:0] wd;
    bit          rdy;
    bit          so;
    logic [63:0] dout;
    bit          fe, fo, err, stl;
  } vec_t;

  vec_t vecs[16];

  initial begin
    bit pol;
    // pol wv ro data | wr_ready(pre-edge) so dout fe fo err stall (post-edge)
    vecs[0]  = '{0, 1, 0, 64'hA5, 1, 0, 64'h0,  1, 0, 0, 0};
    vecs[1]  = '{1, 0, 1, 64'h0,  1, 1, 64'hA5, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 64'h0,  1, 0, 64'h0,  0, 0, 0, 0};
    vecs[3]  = '{1, 1, 0, 64'h11, 1, 0, 64'h0,  0, 1, 0, 0};
    vecs[4]  = '{0, 0, 0, 64'h0,  1, 0, 64'h0,  0, 1, 0, 0};
    vecs[5]  = '{1, 1, 0, 64'h22, 0, 0, 64'h0,  0, 1, 1, 0};
    vecs[6]  = '{0, 0, 1, 64'h0,  1, 1, 64'h11, 0, 0, 1, 0};
    vecs[7]  = '{1, 0, 0, 64'h0,  1, 0, 64'h0,  0, 0, 1, 0};
    vecs[8]  = '{0, 1, 0, 64'h33, 1, 0, 64'h0,  1, 0, 1, 0};
    vecs[9]  = '{1, 0, 0, 64'h0,  1, 0, 64'h0,  1, 0, 1, 0};
    vecs[10] = '{0, 0, 0, 64'h0,  0, 0, 64'h0,  1, 0, 1, 0};
    vecs[11] = '{1, 0, 0, 64'h0,  1, 0, 64'h0,  1, 0, 1, 0};
    vecs[12] = '{0, 0, 0, 64'h0,  0, 0, 64'h0,  1, 0, 1, 0};
    vecs[13] = '{1, 0, 0, 64'h0,  1, 0, 64'h0,  1, 0, 1, 1};
    vecs[14] = '{0, 0, 1, 64'h0,  0, 0, 64'h0,  1, 0, 1, 1};
    vecs[15] = '{1, 0, 1, 64'h0,  1, 1, 64'h33, 0, 0, 1, 0};

    reset = 1'b0; polarity = 1'b0; bus.wr_valid = 1'b1; bus.wr_data = 64'hDEAD; bus.ro = 1'b1;

    // Reset held for two edges with write and ready asserted.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      polarity = ~polarity;
      chk("rst_so", {63'd0, bus.so}, 64'd0);
      chk("rst_dout", bus.dout, 64'd0);
      chk("rst_full_even", {63'd0, full_even}, 64'd0);
      chk("rst_full_odd", {63'd0, full_odd}, 64'd0);
      chk("rst_err", {63'd0, err_overflow}, 64'd0);
      chk("rst_stall", {63'd0, stall}, 64'd0);
    end
    reset = 1'b1; bus.wr_valid = 1'b0; polarity = 1'b0; #1;
    chk("rel_wr_ready_even", {63'd0, bus.wr_ready}, 64'd1);
    polarity = 1'b1; #1;
    chk("rel_wr_ready_odd", {63'd0, bus.wr_ready}, 64'd1);

    // Constant vector table: basic send, overflow, stall at limit 3.
    foreach (vecs[i]) begin
      polarity = vecs[i].pol; bus.wr_valid = vecs[i].wv;
      bus.wr_data = vecs[i].wd; bus.ro = vecs[i].ro;
      #1;
      chk($sformatf("v%0d_wr_ready", i), {63'd0, bus.wr_ready}, {63'd0, vecs[i].rdy});
      @(posedge clk); #1;
      chk($sformatf("v%0d_so", i), {63'd0, bus.so}, {63'd0, vecs[i].so});
      chk($sformatf("v%0d_dout", i), bus.dout, vecs[i].dout);
      chk($sformatf("v%0d_full_even", i), {63'd0, full_even}, {63'd0, vecs[i].fe});
      chk($sformatf("v%0d_full_odd", i), {63'd0, full_odd}, {63'd0, vecs[i].fo});
      chk($sformatf("v%0d_err", i), {63'd0, err_overflow}, {63'd0, vecs[i].err});
      chk($sformatf("v%0d_stall", i), {63'd0, stall}, {63'd0, vecs[i].stl});
    end

    // Mid-operation reset: both VCs loaded, reset lands on a send edge.
    step(0, 0, 0, 64'h0, 0);
    step(1, 0, 1, 64'hAA, 0);
    step(1, 1, 1, 64'hBB, 0);
    step(0, 0, 0, 64'h0, 1);
    chk("midrst_so", {63'd0, bus.so}, 64'd0);
    chk("midrst_empty", {62'd0, full_even, full_odd}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      step(1, i[0], 0, 64'h0, 1);
      chk("midrst_no_pkt", {63'd0, bus.so}, 64'd0);
    end

    // Randomized traffic, mostly toggling phase with occasional held phase.
    pol = 0;
    for (int i = 0; i < 3000; i++) begin
      pol = ($urandom_range(0, 9) == 0) ? pol : !pol;
      step(($urandom_range(0, 199) != 0), pol, ($urandom_range(0, 9) < 7),
           {$urandom, $urandom}, ($urandom_range(0, 9) < 6));
    end

`ifdef OUTPUT_CONTROLLER_PKT_COUNT_EN
    // Back-to-back sends, then run the counter through its wrap.
    step(0, 0, 0, 64'h0, 1);
    for (int i = 0; i < 6; i++) step(1, i[0], 1, 64'(i + 1), 1);
    chk("pkt_count_5", {48'd0, pkt_count}, 64'd5);
    for (int i = 6; i < 65536; i++) step(1, i[0], 1, 64'(i + 1), 1);
    chk("pkt_count_65535", {48'd0, pkt_count}, 64'd65535);
    step(1, 0, 1, 64'h5, 1);
    chk("pkt_count_wrap", {48'd0, pkt_count}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
